// File: rtl/operand_fetch_if.sv
// Handshake bundle of the operand stage: the fetch-side instruction offer and
// the execute-side operand bundle. The stage itself is the slave; the
// surrounding pipeline (fetch and execute) acts as master.
interface operand_fetch_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  // fetch -> operand stage
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [31:0]           instr_i;
  logic [31:0]           pc_i;
  // operand stage -> execute
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [31:0]           out_pc_o;
  logic [31:0]           out_instr_o;
  logic [DATA_WIDTH-1:0] out_rs1_o;
  logic [DATA_WIDTH-1:0] out_rs2_o;
  logic [ADDR_WIDTH-1:0] out_rd_o;

  modport slave (
    input  in_valid_i, instr_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_instr_o,
           out_rs1_o, out_rs2_o, out_rd_o
  );

  modport master (
    output in_valid_i, instr_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_instr_o,
           out_rs1_o, out_rs2_o, out_rd_o
  );
endinterface

// File: rtl/operand_fetch.sv
// Decode-side operand stage: reads rs1/rs2 from the register file, applies
// EX/WB bypasses, detects load-use hazards and registers a resolved operand
// bundle for execute behind a valid/ready handshake.
module operand_fetch #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  operand_fetch_if.slave        bus,
  output logic [ADDR_WIDTH-1:0] raddr_a_o,
  output logic [ADDR_WIDTH-1:0] raddr_b_o,
  input  logic [DATA_WIDTH-1:0] rdata_a_i,
  input  logic [DATA_WIDTH-1:0] rdata_b_i,
  input  logic                  ex_we_i,
  input  logic                  ex_is_load_i,
  input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_waddr_i,
  input  logic [DATA_WIDTH-1:0] wb_wdata_i,
  input  logic                  flush_i
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [ADDR_WIDTH-1:0] rs1_idx, rs2_idx;
  logic                  use_rs1, use_rs2;
  logic                  stall, accept, in_ready;
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val;

  logic                  out_valid_q, out_valid_d;
  logic [31:0]           out_pc_q, out_pc_d;
  logic [31:0]           out_instr_q, out_instr_d;
  logic [DATA_WIDTH-1:0] out_rs1_q, out_rs1_d;
  logic [DATA_WIDTH-1:0] out_rs2_q, out_rs2_d;
  logic [ADDR_WIDTH-1:0] out_rd_q, out_rd_d;

  assign rs1_idx   = bus.instr_i[15 +: ADDR_WIDTH];
  assign rs2_idx   = bus.instr_i[20 +: ADDR_WIDTH];
  assign raddr_a_o = rs1_idx;
  assign raddr_b_o = rs2_idx;

  // Bypass priority: x0, then a non-load EX result, then the WB write (the
  // register file commits it on the same edge, so the read port is stale).
  function automatic logic [DATA_WIDTH-1:0] resolve(
    input logic                  used,
    input logic [ADDR_WIDTH-1:0] idx,
    input logic [DATA_WIDTH-1:0] rf_data,
    input logic                  ex_we,
    input logic                  ex_ld,
    input logic [ADDR_WIDTH-1:0] ex_addr,
    input logic [DATA_WIDTH-1:0] ex_data,
    input logic                  wb_we,
    input logic [ADDR_WIDTH-1:0] wb_addr,
    input logic [DATA_WIDTH-1:0] wb_data
  );
    if (!used || idx == '0)                         return '0;
    else if (ex_we && !ex_ld && ex_addr == idx)     return ex_data;
    else if (wb_we && wb_addr == idx)               return wb_data;
    else                                            return rf_data;
  endfunction

  // Decode which source operands the opcode actually reads.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise the
    // unlisted opcodes would infer latches.
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (bus.instr_i[6:0])
      OPC_OP, OPC_STORE, OPC_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  // Resolve both operands through the bypass network.
  always_comb begin
    rs1_val = resolve(use_rs1, rs1_idx, rdata_a_i, ex_we_i, ex_is_load_i,
                      ex_waddr_i, ex_wdata_i, wb_we_i, wb_waddr_i, wb_wdata_i);
    rs2_val = resolve(use_rs2, rs2_idx, rdata_b_i, ex_we_i, ex_is_load_i,
                      ex_waddr_i, ex_wdata_i, wb_we_i, wb_waddr_i, wb_wdata_i);
  end

  // A load in EX has no data yet: hold off any consumer of its destination.
  assign stall = ex_we_i && ex_is_load_i && (ex_waddr_i != '0) &&
                 ((use_rs1 && ex_waddr_i == rs1_idx) ||
                  (use_rs2 && ex_waddr_i == rs2_idx));

  assign in_ready       = !flush_i && !stall && (!out_valid_q || bus.out_ready_i);
  assign accept         = bus.in_valid_i && in_ready;
  assign bus.in_ready_o = in_ready;

  // Next-state: flush kills, accept loads, a consumed/empty slot drains,
  // otherwise the bundle holds untouched under backpressure.
  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_rs1_d   = out_rs1_q;
    out_rs2_d   = out_rs2_q;
    out_rd_d    = out_rd_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_pc_d    = bus.pc_i;
      out_instr_d = bus.instr_i;
      out_rs1_d   = rs1_val;
      out_rs2_d   = rs2_val;
      out_rd_d    = bus.instr_i[7 +: ADDR_WIDTH];
    end else if (bus.out_ready_i || !out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  // Output bundle register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_rd_q    <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      out_rd_q    <= out_rd_d;
    end
  end

  assign bus.out_valid_o = out_valid_q;
  assign bus.out_pc_o    = out_pc_q;
  assign bus.out_instr_o = out_instr_q;
  assign bus.out_rs1_o   = out_rs1_q;
  assign bus.out_rs2_o   = out_rs2_q;
  assign bus.out_rd_o    = out_rd_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: a stimulus process predicts each
// accepted bundle from the architectural rules and queues it; an independent
// monitor compares whatever the stage presents against the queue head.
module tb_operand_fetch;

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ex_we;
    logic        ex_ld;
    logic [4:0]  ex_a;
    logic [31:0] ex_d;
    logic        wb_we;
    logic [4:0]  wb_a;
    logic [31:0] wb_d;
    logic        flush;
    logic        ordy;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } bundle_t;

  logic        clk;
  logic        rst_n;
  logic [4:0]  raddr_a_o, raddr_b_o;
  logic [31:0] rdata_a_i, rdata_b_i;
  logic        ex_we_i, ex_is_load_i, wb_we_i, flush_i;
  logic [4:0]  ex_waddr_i, wb_waddr_i;
  logic [31:0] ex_wdata_i, wb_wdata_i;

  logic [31:0] rf [32];
  bundle_t     q [$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] next_pc = 32'h1000;

  operand_fetch_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus_if ();

  operand_fetch #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .raddr_a_o    (raddr_a_o),
    .raddr_b_o    (raddr_b_o),
    .rdata_a_i    (rdata_a_i),
    .rdata_b_i    (rdata_b_i),
    .ex_we_i      (ex_we_i),
    .ex_is_load_i (ex_is_load_i),
    .ex_waddr_i   (ex_waddr_i),
    .ex_wdata_i   (ex_wdata_i),
    .wb_we_i      (wb_we_i),
    .wb_waddr_i   (wb_waddr_i),
    .wb_wdata_i   (wb_wdata_i),
    .flush_i      (flush_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: combinational reads, write on the WB edge.
  assign rdata_a_i = rf[raddr_a_o];
  assign rdata_b_i = rf[raddr_b_o];
  always @(posedge clk)
    if (wb_we_i && wb_waddr_i != 5'd0) rf[wb_waddr_i] <= wb_wdata_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: which sources an instruction reads, from its major opcode.
  function automatic logic [1:0] reads(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0100011, 7'b1100011: return 2'b11;
      7'b0010011, 7'b0000011, 7'b1100111: return 2'b01;
      default:                             return 2'b00;
    endcase
  endfunction

  // Reference: the newest value of register idx visible to this instruction.
  function automatic logic [31:0] value_of(input logic used, input logic [4:0] idx, input stim_t s);
    if (!used || idx == 5'd0)                 return 32'd0;
    if (s.ex_we && !s.ex_ld && s.ex_a == idx) return s.ex_d;
    if (s.wb_we && s.wb_a == idx)             return s.wb_d;
    return rf[idx];
  endfunction

  function automatic stim_t quiet();
    stim_t s;
    s.v = 1'b0; s.instr = 32'h0000_0013; s.pc = 32'd0;
    s.ex_we = 1'b0; s.ex_ld = 1'b0; s.ex_a = 5'd0; s.ex_d = 32'd0;
    s.wb_we = 1'b0; s.wb_a = 5'd0; s.wb_d = 32'd0;
    s.flush = 1'b0; s.ordy = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [6:0] op;
    int k;
    ops = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0000011,
            7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011};
    k  = int'($urandom_range(0, 10));
    op = (k == 10) ? 7'($urandom) : ops[k];
    return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            3'($urandom), 5'($urandom_range(0, 31)), op};
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.v     = ($urandom_range(0, 9) < 8);
    s.instr = rand_instr();
    s.pc    = $urandom;
    s.ex_we = $urandom_range(0, 1) == 1;
    s.ex_ld = $urandom_range(0, 3) == 0;
    s.ex_a  = 5'($urandom_range(0, 7));
    s.ex_d  = $urandom;
    s.wb_we = $urandom_range(0, 1) == 1;
    s.wb_a  = 5'($urandom_range(0, 7));
    s.wb_d  = $urandom;
    s.flush = $urandom_range(0, 19) == 0;
    s.ordy  = $urandom_range(0, 9) < 7;
    return s;
  endfunction

  // One cycle: drive after the falling edge, predict ready/accept, queue the
  // expected bundle once the rising edge has taken it.
  task automatic step(input stim_t s);
    logic [1:0] u;
    logic       stall_m, rdy_m, acc;
    bundle_t    e;
    @(negedge clk);
    bus_if.in_valid_i  = s.v;
    bus_if.instr_i     = s.instr;
    bus_if.pc_i        = s.pc;
    ex_we_i            = s.ex_we;
    ex_is_load_i       = s.ex_ld;
    ex_waddr_i         = s.ex_a;
    ex_wdata_i         = s.ex_d;
    wb_we_i            = s.wb_we;
    wb_waddr_i         = s.wb_a;
    wb_wdata_i         = s.wb_d;
    flush_i            = s.flush;
    bus_if.out_ready_i = s.ordy;
    #1;
    u       = reads(s.instr[6:0]);
    stall_m = s.ex_we && s.ex_ld && s.ex_a != 5'd0 &&
              ((u[0] && s.ex_a == s.instr[19:15]) || (u[1] && s.ex_a == s.instr[24:20]));
    rdy_m   = !s.flush && !stall_m && (q.size() == 0 || s.ordy);
    acc     = s.v && rdy_m;
    check("in_ready", 32'(bus_if.in_ready_o), 32'(rdy_m));
    check("raddr_a", 32'(raddr_a_o), 32'(s.instr[19:15]));
    check("raddr_b", 32'(raddr_b_o), 32'(s.instr[24:20]));
    e.pc    = s.pc;
    e.instr = s.instr;
    e.rd    = s.instr[11:7];
    e.rs1   = value_of(u[0], s.instr[19:15], s);
    e.rs2   = value_of(u[1], s.instr[24:20], s);
    @(posedge clk);
    if (acc) q.push_back(e);
    #1;
  endtask

  // Monitor: compare the presented bundle to the queue head each cycle and
  // retire it when execute takes it or a flush kills it.
  initial begin
    bundle_t e;
    logic    mv;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        mv = q.size() != 0;
        check("out_valid", 32'(bus_if.out_valid_o), 32'(mv));
        if (mv) begin
          e = q[0];
          check("out_pc", bus_if.out_pc_o, e.pc);
          check("out_instr", bus_if.out_instr_o, e.instr);
          check("out_rs1", bus_if.out_rs1_o, e.rs1);
          check("out_rs2", bus_if.out_rs2_o, e.rs2);
          check("out_rd", 32'(bus_if.out_rd_o), 32'(e.rd));
          if (bus_if.out_ready_i || flush_i) q.delete(0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    logic [31:0] i_add, i_addi, i_sub;
    i_add  = {7'd0, 5'd0, 5'd5, 3'd0, 5'd3, 7'b0110011};   // add  x3,x5,x0
    i_addi = {12'd7, 5'd0, 3'd0, 5'd1, 7'b0010011};        // addi x1,x0,7
    i_sub  = {7'b0100000, 5'd4, 5'd1, 3'd0, 5'd2, 7'b0110011}; // sub x2,x1,x4

    for (int r = 0; r < 32; r++) rf[r] = (r == 0) ? 32'd0 : 32'h100 + 32'(r);
    rf[5] = 32'h11;
    rst_n = 1'b0;
    s = quiet();
    bus_if.in_valid_i = 1'b0; bus_if.instr_i = s.instr; bus_if.pc_i = 32'd0;
    bus_if.out_ready_i = 1'b1;
    ex_we_i = 1'b0; ex_is_load_i = 1'b0; ex_waddr_i = 5'd0; ex_wdata_i = 32'd0;
    wb_we_i = 1'b0; wb_waddr_i = 5'd0; wb_wdata_i = 32'd0; flush_i = 1'b0;

    // Reset state.
    #12;
    check("rst_valid", 32'(bus_if.out_valid_o), 32'd0);
    check("rst_pc", bus_if.out_pc_o, 32'd0);
    check("rst_rs1", bus_if.out_rs1_o, 32'd0);
    check("rst_rd", 32'(bus_if.out_rd_o), 32'd0);
    check("rst_in_ready", 32'(bus_if.in_ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic flow.
    s = quiet(); s.v = 1'b1; s.instr = i_add; s.pc = 32'h100; step(s);
    check("basic_valid", 32'(bus_if.out_valid_o), 32'd1);
    check("basic_rs1", bus_if.out_rs1_o, 32'h11);
    check("basic_rs2", bus_if.out_rs2_o, 32'd0);
    check("basic_rd", 32'(bus_if.out_rd_o), 32'd3);

    // EX beats WB beats register file.
    rf[5] = 32'hCC;
    s.pc = 32'h104; s.ex_we = 1'b1; s.ex_a = 5'd5; s.ex_d = 32'hAA;
    s.wb_we = 1'b1; s.wb_a = 5'd5; s.wb_d = 32'hBB; step(s);
    check("ex_prio_rs1", bus_if.out_rs1_o, 32'hAA);
    s.pc = 32'h108; s.ex_we = 1'b0; step(s);
    check("wb_prio_rs1", bus_if.out_rs1_o, 32'hBB);

    // x0 is never bypassed.
    s = quiet(); s.v = 1'b1; s.instr = i_addi; s.pc = 32'h10C;
    s.ex_we = 1'b1; s.ex_a = 5'd0; s.ex_d = 32'hFFFF; step(s);
    check("x0_rs1", bus_if.out_rs1_o, 32'd0);

    // Load-use: one bubble, then WB supplies the loaded value.
    s = quiet(); s.v = 1'b1; s.instr = i_sub; s.pc = 32'h110;
    s.ex_we = 1'b1; s.ex_ld = 1'b1; s.ex_a = 5'd4; step(s);
    check("lu_bubble", 32'(bus_if.out_valid_o), 32'd0);
    s.ex_we = 1'b0; s.ex_ld = 1'b0; s.wb_we = 1'b1; s.wb_a = 5'd4; s.wb_d = 32'h40; step(s);
    check("lu_rs2", bus_if.out_rs2_o, 32'h40);

    // Backpressure: hold three cycles with changing bypasses, then release.
    s = quiet(); s.v = 1'b1; s.instr = i_add; s.pc = 32'h114; step(s);
    for (int k = 0; k < 3; k++) begin
      s = rand_stim(); s.v = 1'b1; s.instr = i_sub; s.pc = 32'h118;
      s.flush = 1'b0; s.ordy = 1'b0; step(s);
      check("bp_hold_instr", bus_if.out_instr_o, i_add);
    end
    s = quiet(); s.v = 1'b1; s.instr = i_sub; s.pc = 32'h118; step(s);
    check("bp_release_instr", bus_if.out_instr_o, i_sub);

    // Flush kills the held bundle and blocks the offer.
    s.pc = 32'h11C; s.flush = 1'b1; step(s);
    check("flush_valid", 32'(bus_if.out_valid_o), 32'd0);

    // Asynchronous reset mid-cycle with a valid bundle held.
    s = quiet(); s.v = 1'b1; s.instr = i_addi; s.pc = 32'h120; s.ordy = 1'b0; step(s);
    @(negedge clk);
    bus_if.in_valid_i = 1'b0;
    #3;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("arst_valid", 32'(bus_if.out_valid_o), 32'd0);
    check("arst_instr", bus_if.out_instr_o, 32'd0);
    check("arst_rs1", bus_if.out_rs1_o, 32'd0);
    @(negedge clk);
    #3;
    rst_n = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) step(rand_stim());

    // Drain and confirm nothing is left outstanding.
    for (int n = 0; n < 3; n++) step(quiet());
    check("drain_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
